// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Table of 2-bit saturating counters indexed by PC bits, trained by
//            resolved branches, with saturating branch/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int         INDEX_BITS = 4,
    parameter logic [1:0] INIT_STATE = 2'b11,
    parameter int         CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          pc_i,
    output logic                 predict_o,
    input  logic                 update_i,
    input  logic [31:0]          update_pc_i,
    input  logic                 update_taken_i,
    input  logic                 update_predict_i,
    output logic                 mispredict_o,
    output logic [CNT_WIDTH-1:0] branch_cnt_o,
    output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

    localparam int         c_ENTRIES = 2 ** INDEX_BITS;
    localparam logic [1:0] c_SNT     = 2'b00;
    localparam logic [1:0] c_WNT     = 2'b01;
    localparam logic [1:0] c_WT      = 2'b10;
    localparam logic [1:0] c_ST      = 2'b11;

    logic [1:0]            r_table [c_ENTRIES];
    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [INDEX_BITS-1:0] w_update_idx;
    logic [1:0]            w_cur_state;
    logic [1:0]            w_next_state;
    logic [CNT_WIDTH-1:0]  r_branch_cnt;
    logic [CNT_WIDTH-1:0]  r_mispredict_cnt;
    logic                  w_unused;

    assign w_lookup_idx = pc_i[INDEX_BITS+1:2];
    assign w_update_idx = update_pc_i[INDEX_BITS+1:2];
    assign w_cur_state  = r_table[w_update_idx];
    assign w_unused     = ^{pc_i[31:INDEX_BITS+2], pc_i[1:0],
                            update_pc_i[31:INDEX_BITS+2], update_pc_i[1:0]};

    // State register: only the entry being trained moves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_table[i] <= INIT_STATE;
            end
        end else if (update_i) begin
            r_table[w_update_idx] <= w_next_state;
        end
    end

    // Next-state logic for the trained entry.
    always_comb begin
        w_next_state = w_cur_state;
        case (w_cur_state)
            c_SNT:   w_next_state = update_taken_i ? c_WNT : c_SNT;
            c_WNT:   w_next_state = update_taken_i ? c_WT  : c_SNT;
            c_WT:    w_next_state = update_taken_i ? c_ST  : c_WNT;
            c_ST:    w_next_state = update_taken_i ? c_ST  : c_WT;
            default: w_next_state = INIT_STATE;
        endcase
    end

    // Output logic: lookup reads the registered table, so there is no bypass.
    always_comb begin
        predict_o    = r_table[w_lookup_idx][1];
        mispredict_o = update_i & (update_taken_i != update_predict_i);
    end

    // Mispredicts only count alongside a branch count, so mispredict <= branch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (update_i) begin
            if (!(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            end
            if (mispredict_o && !(&r_mispredict_cnt)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign branch_cnt_o     = r_branch_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed, table-driven bench for branch_predictor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        update_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        update_predict_i;

    logic        predict_o, mispredict_o;
    logic [31:0] branch_cnt_o, mispredict_cnt_o;
    logic        predict4_o, mispredict4_o;
    logic [3:0]  branch_cnt4_o, mispredict_cnt4_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    branch_predictor #(.INDEX_BITS(4), .INIT_STATE(2'b11), .CNT_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .predict_o(predict_o),
        .update_i(update_i), .update_pc_i(update_pc_i),
        .update_taken_i(update_taken_i), .update_predict_i(update_predict_i),
        .mispredict_o(mispredict_o), .branch_cnt_o(branch_cnt_o),
        .mispredict_cnt_o(mispredict_cnt_o)
    );

    branch_predictor #(.INDEX_BITS(4), .INIT_STATE(2'b11), .CNT_WIDTH(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .predict_o(predict4_o),
        .update_i(update_i), .update_pc_i(update_pc_i),
        .update_taken_i(update_taken_i), .update_predict_i(update_predict_i),
        .mispredict_o(mispredict4_o), .branch_cnt_o(branch_cnt4_o),
        .mispredict_cnt_o(mispredict_cnt4_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic        upd;
        logic [31:0] upc;
        logic        taken;
        logic        pred;
        logic        exp_p;
        logic        exp_m;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_upd(input logic u, input logic [31:0] upc, input logic t, input logic p);
        update_i         = u;
        update_pc_i      = upc;
        update_taken_i   = t;
        update_predict_i = p;
    endtask

    initial begin
        // Entry 2 (pc 0x8 / alias 0x48) trained down from 11
        vecs[0]  = '{32'h08, 1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{32'h48, 1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{32'h08, 1'b1, 32'h08, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h08, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h48, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h0C, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        // Entry 4 (pc 0x10): down to 00, up five times with saturation
        vecs[6]  = '{32'h10, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h10, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'h10, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{32'h10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{32'h10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{32'h10, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        // Entry 2 raised to 10, then same-cycle lookup+update (no bypass)
        vecs[17] = '{32'h08, 1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{32'h08, 1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{32'h08, 1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[20] = '{32'h08, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        // update_i=0 with live-looking side inputs must change nothing
        vecs[21] = '{32'h08, 1'b0, 32'h08, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{32'h08, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_i = 1'b1;
        pc_i  = 32'h0;
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("reset_pred_0x0", {31'b0, predict_o}, 32'h1);
        pc_i = 32'h3C; #1;
        check("reset_pred_0x3C", {31'b0, predict_o}, 32'h1);
        pc_i = 32'h40; #1;
        check("reset_pred_0x40", {31'b0, predict_o}, 32'h1);
        check("reset_branch_cnt", branch_cnt_o, 32'h0);
        check("reset_mispred_cnt", mispredict_cnt_o, 32'h0);
        check("reset_branch_cnt4", {28'b0, branch_cnt4_o}, 32'h0);

        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk_i);
            pc_i = vecs[i].pc;
            drive_upd(vecs[i].upd, vecs[i].upc, vecs[i].taken, vecs[i].pred);
            #1;
            check($sformatf("vec%0d_predict", i), {31'b0, predict_o}, {31'b0, vecs[i].exp_p});
            check($sformatf("vec%0d_mispredict", i), {31'b0, mispredict_o}, {31'b0, vecs[i].exp_m});
        end
        @(negedge clk_i);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("table_branch_cnt", branch_cnt_o, 32'd15);
        check("table_mispred_cnt", mispredict_cnt_o, 32'd7);

        // Async reset between edges while an update is pending
        @(negedge clk_i);
        pc_i = 32'h08;
        drive_upd(1'b1, 32'h08, 1'b1, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_pred", {31'b0, predict_o}, 32'h1);
        check("async_rst_branch_cnt", branch_cnt_o, 32'h0);
        check("async_rst_mispred_cnt", mispredict_cnt_o, 32'h0);
        @(posedge clk_i);
        #1;
        check("rst_edge_branch_cnt", branch_cnt_o, 32'h0);
        check("rst_edge_mispred_cnt", mispredict_cnt_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        for (int e = 0; e < 16; e++) begin
            pc_i = 32'(e * 4);
            #1;
            check($sformatf("post_rst_entry%0d", e), {31'b0, predict_o}, 32'h1);
        end

        // Ten updates, mispredicts on k = 2, 5, 9
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            pc_i = 32'h20;
            drive_upd(1'b1, 32'h20, 1'b1, (k == 2 || k == 5 || k == 9) ? 1'b0 : 1'b1);
            #1;
            check($sformatf("perf_mispredict_k%0d", k), {31'b0, mispredict_o},
                  (k == 2 || k == 5 || k == 9) ? 32'h1 : 32'h0);
        end
        @(negedge clk_i);
        drive_upd(1'b0, 32'h20, 1'b1, 1'b0);
        #1;
        check("idle_mispredict", {31'b0, mispredict_o}, 32'h0);
        check("perf10_branch_cnt", branch_cnt_o, 32'd10);
        check("perf10_mispred_cnt", mispredict_cnt_o, 32'd3);
        check("perf10_branch_cnt4", {28'b0, branch_cnt4_o}, 32'd10);
        check("perf10_mispred_cnt4", {28'b0, mispredict_cnt4_o}, 32'd3);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            drive_upd(1'b1, 32'h20, 1'b1, 1'b0);
        end
        @(negedge clk_i);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("perf20_branch_cnt", branch_cnt_o, 32'd20);
        check("perf20_mispred_cnt", mispredict_cnt_o, 32'd13);
        check("perf20_branch_cnt4_sat", {28'b0, branch_cnt4_o}, 32'd15);
        check("perf20_mispred_cnt4", {28'b0, mispredict_cnt4_o}, 32'd13);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            drive_upd(1'b1, 32'h20, 1'b0, 1'b1);
        end
        @(negedge clk_i);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("perf25_branch_cnt", branch_cnt_o, 32'd25);
        check("perf25_mispred_cnt", mispredict_cnt_o, 32'd18);
        check("perf25_branch_cnt4_sat", {28'b0, branch_cnt4_o}, 32'd15);
        check("perf25_mispred_cnt4_sat", {28'b0, mispredict_cnt4_o}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
